triangle_source_scheduler: RTL and testbench
============================================

Name: triangle_source_scheduler

Overview:
- Frame-level scheduler that shares the single triangle/vertex input of the rasterizer among NUM_SOURCES vertex generators (player sprite, obstacles, track, etc.).
- On each frame_start it launches the enabled sources one at a time, in ascending index order, with a one-cycle activate pulse.
- It forwards the selected source's vertex/color/new_triangle stream through one register stage and reports frame completion.
- Per-source timeouts prevent a dead source from stalling the frame.

Parameters:
- NUM_SOURCES, 4, number of generator ports (1..8).
- START_TIMEOUT, 4, cycles allowed after activate for src_active to rise.
- STREAM_TIMEOUT, 1024, maximum cycles a source may remain in STREAM.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- frame_start  input  1  one-cycle request to schedule a frame
- source_enable  input  NUM_SOURCES  per-source enable mask, sampled at accepted frame_start
- src_activate  output  NUM_SOURCES  one-cycle launch pulse per source
- src_vertex  input  NUM_SOURCES*48  per-source {x,y,z}, signed 16 bits each
- src_color  input  NUM_SOURCES*16  per-source color
- src_new_triangle  input  NUM_SOURCES  first vertex of a triangle
- src_active  input  NUM_SOURCES  source busy; vertex data valid the cycle after active is high
- vertex_out  output  48  forwarded vertex
- color_out  output  16  forwarded color
- new_triangle_out  output  1  qualified first-vertex flag
- valid_out  output  1  vertex_out valid this cycle
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse at end of frame
- frame_overrun  output  1  one-cycle pulse when frame_start arrives while busy
- triangle_count  output  16  triangles forwarded in current/last frame
- timeout_flags  output  NUM_SOURCES  sticky per-frame source timeout flags

Behaviour:
- Reset: all outputs 0; state IDLE; sel 0; act_q 0; counters 0. Reset mid-frame aborts immediately; no activate is issued in the cycle after reset.
- Source timing contract: data on src_vertex[i] is valid in cycle c iff src_active[i] was 1 in cycle c-1. The scheduler keeps act_q <= src_active[sel].
- IDLE:
  - On frame_start: latch the enable mask, clear triangle_count and timeout_flags.
  - Mask zero: frame_done=1 next cycle, busy stays 0, remain IDLE.
  - Otherwise: sel = lowest enabled index, busy<=1, go to LAUNCH.
- LAUNCH: src_activate[sel]=1 for exactly this cycle; clear the wait counter; go to WAIT_START.
- WAIT_START:
  - src_active[sel]=1: go to STREAM, act_q<=1.
  - Otherwise increment the counter. On reaching START_TIMEOUT, set timeout_flags[sel] and go to NEXT.
- STREAM:
  - Registered outputs each cycle: vertex_out<=src_vertex[sel]; color_out<=src_color[sel]; valid_out<=act_q; new_triangle_out<=act_q & src_new_triangle[sel]. Latency is one cycle from the source's valid vertex.
  - triangle_count increments on each new_triangle_out (saturates at 16'hFFFF).
  - act_q=1 and src_active[sel]=0: last vertex is captured this cycle; go to NEXT.
  - Stream counter reaches STREAM_TIMEOUT: set timeout_flags[sel]; valid_out<=0 from the next cycle; go to NEXT.
- NEXT (1 cycle):
  - valid_out<=0 and new_triangle_out<=0.
  - sel = next enabled index above sel; go to LAUNCH.
  - If none remain, go to DONE.
- DONE: frame_done=1 for one cycle; busy<=0; go to IDLE.
- Outside STREAM, valid_out and new_triangle_out are 0. vertex_out and color_out hold their last value.
- frame_start while busy (any state except IDLE): ignored; frame_overrun=1 for one cycle. The current frame is unaffected.
- frame_start in the same cycle as rst: rst wins.
- A source's active input is ignored unless that source is sel and the state is WAIT_START or STREAM.

Decomposition:
- Package triangle_sched_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_START, STREAM, NEXT, DONE);
  - VERTEX_W=48, COLOR_W=16, COORD_W=16.
- Sub-module next_source_finder: combinational search for the lowest set mask bit strictly above a given index, returning found and index. It is used for both the first and subsequent selections, with index -1 meaning "from the start".

Test Plan:
1. NUM_SOURCES=4, enable=4'b0001, source 0 is a 30-vertex box model:
   - src_activate[0] high for exactly 1 cycle.
   - 30 valid_out cycles and 10 new_triangle_out pulses; triangle_count=10.
   - frame_done pulses once; busy returns to 0.
2. enable=4'b1011, sources emit 30/6/12 vertices:
   - Launch order 0,1,3; src_activate[2] never asserted.
   - triangle_count=16; vertices arrive in contiguous per-source order.
3. enable=4'b0011, source 0 never raises active:
   - timeout_flags=4'b0001 after 4 WAIT_START cycles.
   - Source 1 then launched and fully streamed; frame_done still pulses.
4. enable=4'b0000: frame_done pulses on the cycle after frame_start; no src_activate; busy stays 0; triangle_count=0.
5. frame_start pulsed at vertex 15 of source 0: frame_overrun=1 for 1 cycle; the stream completes unchanged with 30 vertices.
6. rst asserted at vertex 12 of source 0, with the source model also reset:
   - Next cycle all outputs are 0 and state is IDLE.
   - A subsequent frame_start yields a complete 30-vertex frame.

Source files
------------

// File: rtl/triangle_sched_pkg.sv
// Shared types and widths for the triangle source scheduler.
package triangle_sched_pkg;
    localparam int VERTEX_W = 48;
    localparam int COLOR_W  = 16;
    localparam int COORD_W  = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_START = 3'd2,
        STREAM     = 3'd3,
        NEXT       = 3'd4,
        DONE       = 3'd5
    } sched_state_e;

    // Width of a source index; never below one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/triangle_source_scheduler_if.sv
// Frame request / source stream / forwarded stream bundle of the scheduler.
interface triangle_source_scheduler_if #(parameter int NUM_SOURCES = 4);
    import triangle_sched_pkg::*;

    logic                                   frame_start;
    logic [NUM_SOURCES-1:0]                 source_enable;
    logic [NUM_SOURCES-1:0]                 src_activate;
    logic [NUM_SOURCES-1:0][VERTEX_W-1:0]   src_vertex;
    logic [NUM_SOURCES-1:0][COLOR_W-1:0]    src_color;
    logic [NUM_SOURCES-1:0]                 src_new_triangle;
    logic [NUM_SOURCES-1:0]                 src_active;
    logic [VERTEX_W-1:0]                    vertex_out;
    logic [COLOR_W-1:0]                     color_out;
    logic                                   new_triangle_out;
    logic                                   valid_out;
    logic                                   busy;
    logic                                   frame_done;
    logic                                   frame_overrun;
    logic [15:0]                            triangle_count;
    logic [NUM_SOURCES-1:0]                 timeout_flags;

    modport slave (
        input  frame_start, source_enable, src_vertex, src_color, src_new_triangle, src_active,
        output src_activate, vertex_out, color_out, new_triangle_out, valid_out,
               busy, frame_done, frame_overrun, triangle_count, timeout_flags
    );

    modport master (
        output frame_start, source_enable, src_vertex, src_color, src_new_triangle, src_active,
        input  src_activate, vertex_out, color_out, new_triangle_out, valid_out,
               busy, frame_done, frame_overrun, triangle_count, timeout_flags
    );
endinterface

// File: rtl/triangle_source_scheduler_next_source_finder.sv
// Finds the lowest set mask bit strictly above i_from; i_from = -1 searches from bit 0.
module next_source_finder
    import triangle_sched_pkg::*;
#(
    parameter  int NUM_SOURCES = 4,
    localparam int SEL_W       = sel_width(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] i_mask,
    input  logic signed [SEL_W:0]  i_from,
    output logic                   o_found,
    output logic [SEL_W-1:0]       o_idx
);
    // Descending scan so the lowest qualifying index is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_from))) begin
                o_found = 1'b1;
                o_idx   = SEL_W'(i);
            end
        end
    end
endmodule

// File: rtl/triangle_source_scheduler.sv
// Launches enabled vertex sources one at a time per frame and forwards the
// selected stream through one register stage, with start/stream timeouts.
module triangle_source_scheduler
    import triangle_sched_pkg::*;
#(
    parameter int NUM_SOURCES    = 4,
    parameter int START_TIMEOUT  = 4,
    parameter int STREAM_TIMEOUT = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    triangle_source_scheduler_if.slave bus
);
    localparam int SEL_W   = sel_width(NUM_SOURCES);
    localparam int CNT_MAX = (STREAM_TIMEOUT > START_TIMEOUT) ? STREAM_TIMEOUT : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_LAUNCH = LAUNCH;
    localparam logic [2:0] S_WAIT   = WAIT_START;
    localparam logic [2:0] S_STREAM = STREAM;
    localparam logic [2:0] S_NEXT   = NEXT;
    localparam logic [2:0] S_DONE   = DONE;

    logic [2:0]             r_state;
    logic [SEL_W-1:0]       r_sel;
    logic [NUM_SOURCES-1:0] r_mask;
    logic                   r_act_q;
    logic [CNT_W-1:0]       r_cnt;
    logic [VERTEX_W-1:0]    r_vertex;
    logic [COLOR_W-1:0]     r_color;
    logic                   r_nt;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overrun;
    logic [15:0]            r_tri;
    logic [NUM_SOURCES-1:0] r_flags;

    logic [NUM_SOURCES-1:0] w_mask;
    logic signed [SEL_W:0]  w_from;
    logic                   w_found;
    logic [SEL_W-1:0]       w_idx;
    logic                   w_src_active;
    logic                   w_nt_cap;
    logic [NUM_SOURCES-1:0] w_activate;

    // In IDLE the search runs over the live enable input from the start.
    always_comb begin
        w_mask = r_mask;
        w_from = {1'b0, r_sel};
        if (r_state == S_IDLE) begin
            w_mask = bus.source_enable;
            w_from = '1;
        end
    end

    next_source_finder #(.NUM_SOURCES(NUM_SOURCES)) u_finder (
        .i_mask  (w_mask),
        .i_from  (w_from),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_src_active = bus.src_active[r_sel];
    assign w_nt_cap     = r_act_q & bus.src_new_triangle[r_sel];

    always_comb begin
        w_activate = '0;
        if (r_state == S_LAUNCH) w_activate[r_sel] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_mask    <= '0;
            r_act_q   <= 1'b0;
            r_cnt     <= '0;
            r_vertex  <= '0;
            r_color   <= '0;
            r_nt      <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_tri     <= '0;
            r_flags   <= '0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= bus.frame_start && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        r_mask  <= bus.source_enable;
                        r_tri   <= '0;
                        r_flags <= '0;
                        if (w_found) begin
                            r_sel   <= w_idx;
                            r_busy  <= 1'b1;
                            r_state <= S_LAUNCH;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_src_active) begin
                        r_act_q <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_STREAM;
                    end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        r_flags[r_sel] <= 1'b1;
                        r_state        <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    r_vertex <= bus.src_vertex[r_sel];
                    r_color  <= bus.src_color[r_sel];
                    r_valid  <= r_act_q;
                    r_nt     <= w_nt_cap;
                    if (w_nt_cap && (r_tri != 16'hFFFF)) r_tri <= r_tri + 16'd1;
                    r_act_q  <= w_src_active;
                    r_cnt    <= r_cnt + 1'b1;
                    // A falling active means this cycle carries the last vertex.
                    if (r_act_q && !w_src_active) begin
                        r_state <= S_NEXT;
                    end else if (r_cnt == CNT_W'(STREAM_TIMEOUT - 1)) begin
                        r_flags[r_sel] <= 1'b1;
                        r_state        <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_valid <= 1'b0;
                    r_nt    <= 1'b0;
                    r_act_q <= 1'b0;
                    if (w_found) begin
                        r_sel   <= w_idx;
                        r_state <= S_LAUNCH;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.src_activate     = w_activate;
    assign bus.vertex_out       = r_vertex;
    assign bus.color_out        = r_color;
    assign bus.new_triangle_out = r_nt;
    assign bus.valid_out        = r_valid;
    assign bus.busy             = r_busy;
    assign bus.frame_done       = r_done;
    assign bus.frame_overrun    = r_overrun;
    assign bus.triangle_count   = r_tri;
    assign bus.timeout_flags    = r_flags;
endmodule

// File: tb/tb_triangle_source_scheduler.sv
// Directed bench: behavioural vertex sources plus stream/launch monitors.
module tb_triangle_source_scheduler;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fs  = 1'b0;
    logic [NS-1:0] en  = '0;

    always #5 clk = ~clk;

    triangle_source_scheduler_if #(.NUM_SOURCES(NS)) bus();

    triangle_source_scheduler #(.NUM_SOURCES(NS), .START_TIMEOUT(4), .STREAM_TIMEOUT(1024)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Source model: active for N cycles after activate, data one cycle behind.
    int                      src_n [NS];
    logic [NS-1:0]           m_act = '0;
    logic [NS-1:0]           m_nt  = '0;
    logic [NS-1:0][47:0]     m_vtx = '0;
    logic [NS-1:0][15:0]     m_col = '0;
    int                      m_left [NS];
    int                      m_seq  [NS];

    assign bus.frame_start      = fs;
    assign bus.source_enable    = en;
    assign bus.src_active       = m_act;
    assign bus.src_vertex       = m_vtx;
    assign bus.src_color        = m_col;
    assign bus.src_new_triangle = m_nt;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (rst) begin
                m_act[i]  <= 1'b0;
                m_left[i] <= 0;
                m_seq[i]  <= 0;
            end else if (bus.src_activate[i] && src_n[i] != 0) begin
                m_act[i]  <= 1'b1;
                m_left[i] <= src_n[i];
                m_seq[i]  <= 0;
            end else if (m_act[i]) begin
                m_left[i] <= m_left[i] - 1;
                if (m_left[i] == 1) m_act[i] <= 1'b0;
                m_vtx[i]  <= {16'(i), 16'(m_seq[i]), 16'(m_seq[i] * 7 + i)};
                m_col[i]  <= {8'(i), 8'(m_seq[i])};
                m_nt[i]   <= (m_seq[i] % 3 == 0);
                m_seq[i]  <= m_seq[i] + 1;
            end
        end
    end

    int            n_valid = 0, n_nt = 0, n_done = 0, n_ovr = 0, n_long = 0;
    int            n_act [NS];
    int            launch_q [$];
    logic [63:0]   vlog [$];
    logic [NS-1:0] prev_act = '0;

    always @(negedge clk) begin
        if (bus.valid_out) begin
            n_valid <= n_valid + 1;
            vlog.push_back({bus.color_out, bus.vertex_out});
        end
        if (bus.new_triangle_out) n_nt   <= n_nt + 1;
        if (bus.frame_done)       n_done <= n_done + 1;
        if (bus.frame_overrun)    n_ovr  <= n_ovr + 1;
        for (int i = 0; i < NS; i++) begin
            if (bus.src_activate[i]) begin
                n_act[i] <= n_act[i] + 1;
                launch_q.push_back(i);
            end
        end
        if (((bus.src_activate & prev_act) != 0) || ($countones(bus.src_activate) > 1)) n_long <= n_long + 1;
        prev_act <= bus.src_activate;
    end

    int n_vec = 0, n_err = 0;
    int s_valid, s_nt, s_done, s_ovr, s_vlog, s_launch;
    int s_act [NS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid = n_valid; s_nt = n_nt; s_done = n_done; s_ovr = n_ovr;
        s_vlog = vlog.size(); s_launch = launch_q.size();
        for (int i = 0; i < NS; i++) s_act[i] = n_act[i];
    endtask

    task automatic start_frame(input logic [NS-1:0] mask);
        @(posedge clk); #1 fs = 1'b1; en = mask;
        @(posedge clk); #1 fs = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!bus.frame_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 64'(bus.frame_done), 64'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    endtask

    // Stream since snapshot must be each enabled source's vertices, in index order.
    task automatic check_stream(input string tag, input logic [NS-1:0] mask);
        int idx = s_vlog, bad = 0, total = 0, li = s_launch, lbad = 0, lcnt = 0;
        logic [63:0] e;
        for (int j = 0; j < NS; j++) begin
            if (mask[j]) begin
                if (li >= launch_q.size() || launch_q[li] != j) lbad++;
                li++; lcnt++;
                for (int q = 0; q < src_n[j]; q++) begin
                    e = {8'(j), 8'(q), 16'(j), 16'(q), 16'(q * 7 + j)};
                    if (idx >= vlog.size() || vlog[idx] !== e) bad++;
                    idx++; total++;
                end
            end
        end
        chk({tag, "_vtx_len"},    64'(vlog.size() - s_vlog), 64'(total));
        chk({tag, "_vtx_order"},  64'(bad), 64'd0);
        chk({tag, "_launch_len"}, 64'(launch_q.size() - s_launch), 64'(lcnt));
        chk({tag, "_launch_ord"}, 64'(lbad), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_vertex"}, 64'(bus.vertex_out), 64'd0);
        chk({tag, "_color"},  64'(bus.color_out), 64'd0);
        chk({tag, "_ctl"},    64'({bus.valid_out, bus.new_triangle_out, bus.busy, bus.frame_done, bus.frame_overrun}), 64'd0);
        chk({tag, "_tri"},    64'(bus.triangle_count), 64'd0);
        chk({tag, "_flags"},  64'(bus.timeout_flags), 64'd0);
        chk({tag, "_act"},    64'(bus.src_activate), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        src_n[0] = 30; src_n[1] = 6; src_n[2] = 5; src_n[3] = 12;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Single 30-vertex source
        snap();
        start_frame(4'b0001);
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.valid_out && k < 50);
        chk("t1_first_valid_lat", 64'(k), 64'd4);
        wait_done("t1", 200);
        chk("t1_valid",  64'(n_valid - s_valid), 64'd30);
        chk("t1_nt",     64'(n_nt - s_nt), 64'd10);
        chk("t1_tri",    64'(bus.triangle_count), 64'd10);
        chk("t1_done",   64'(n_done - s_done), 64'd1);
        chk("t1_act0",   64'(n_act[0] - s_act[0]), 64'd1);
        chk("t1_flags",  64'(bus.timeout_flags), 64'd0);
        check_stream("t1", 4'b0001);

        // Three sources, source 2 masked off
        snap();
        start_frame(4'b1011);
        wait_done("t2", 400);
        chk("t2_tri",    64'(bus.triangle_count), 64'd16);
        chk("t2_valid",  64'(n_valid - s_valid), 64'd48);
        chk("t2_act2",   64'(n_act[2] - s_act[2]), 64'd0);
        chk("t2_done",   64'(n_done - s_done), 64'd1);
        check_stream("t2", 4'b1011);

        // Dead source 0 times out, source 1 still streams
        src_n[0] = 0;
        snap();
        start_frame(4'b0011);
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.src_activate[1] && k < 50);
        chk("t3_launch1_lat", 64'(k), 64'd7);
        chk("t3_flags_early", 64'(bus.timeout_flags), 64'd1);
        wait_done("t3", 200);
        chk("t3_flags",  64'(bus.timeout_flags), 64'd1);
        chk("t3_tri",    64'(bus.triangle_count), 64'd2);
        chk("t3_valid",  64'(n_valid - s_valid), 64'd6);
        chk("t3_done",   64'(n_done - s_done), 64'd1);
        check_stream("t3", 4'b0011);
        src_n[0] = 30;

        // Empty mask: immediate frame_done, counters cleared
        snap();
        start_frame(4'b0000);
        @(negedge clk);
        chk("t4_done_now", 64'(bus.frame_done), 64'd1);
        chk("t4_busy",     64'(bus.busy), 64'd0);
        chk("t4_tri",      64'(bus.triangle_count), 64'd0);
        chk("t4_flags",    64'(bus.timeout_flags), 64'd0);
        @(negedge clk);
        chk("t4_done_once", 64'(bus.frame_done), 64'd0);
        repeat (3) @(negedge clk);
        chk("t4_no_launch", 64'(launch_q.size() - s_launch), 64'd0);
        chk("t4_done_cnt",  64'(n_done - s_done), 64'd1);

        // frame_start mid-stream is an overrun and is otherwise ignored
        snap();
        start_frame(4'b0001);
        k = 0;
        while ((n_valid - s_valid) < 15 && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1 fs = 1'b1;
        @(posedge clk); #1 fs = 1'b0;
        @(negedge clk);
        chk("t5_overrun",  64'(bus.frame_overrun), 64'd1);
        chk("t5_busy",     64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("t5_overrun_once", 64'(bus.frame_overrun), 64'd0);
        wait_done("t5", 200);
        chk("t5_valid",  64'(n_valid - s_valid), 64'd30);
        chk("t5_tri",    64'(bus.triangle_count), 64'd10);
        chk("t5_ovr",    64'(n_ovr - s_ovr), 64'd1);
        chk("t5_done",   64'(n_done - s_done), 64'd1);
        check_stream("t5", 4'b0001);

        // Reset mid-stream aborts, then a clean frame follows
        snap();
        start_frame(4'b0001);
        k = 0;
        while ((n_valid - s_valid) < 12 && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("t6_rst");
        repeat (3) @(negedge clk);
        chk("t6_no_relaunch", 64'(n_act[0] - s_act[0]), 64'd1);
        snap();
        start_frame(4'b0001);
        wait_done("t6", 200);
        chk("t6_valid",  64'(n_valid - s_valid), 64'd30);
        chk("t6_tri",    64'(bus.triangle_count), 64'd10);
        check_stream("t6", 4'b0001);

        chk("activate_single_cycle", 64'(n_long), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
